// File: rtl/sw_pkg.sv
// Shared defaults and helpers for the switch input-buffer slice.
// Holds the output-register state type, one-hot decode and saturating counter increment.
package sw_pkg;

    localparam int PKT_W_DEF   = 32;
    localparam int PORTS_DEF   = 4;
    localparam int DST_LSB_DEF = 0;
    localparam int MAX_PORTS   = 256;
    localparam int MAX_CNT_W   = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } vq_state_e;

    // The top bit of a packet is its valid flag.
    function automatic int valid_idx(input int pkt_w);
        return pkt_w - 1;
    endfunction

    function automatic logic [MAX_PORTS-1:0] onehot(input logic [7:0] dest);
        logic [MAX_PORTS-1:0] v;
        v       = '0;
        v[dest] = 1'b1;
        return v;
    endfunction

    // Increments, but sticks at the all-ones value of a w-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned w);
        logic [MAX_CNT_W-1:0] maxv;
        maxv = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
        return (v >= maxv) ? maxv : v + 1'b1;
    endfunction

endpackage

// File: rtl/ib_fifo.sv
// Show-ahead FIFO for the input buffer.
// Writes while full and reads while empty are ignored; count tracks occupancy 0..DEPTH.
module ib_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             din,
    input  logic                     we,
    input  logic                     re,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doWrite;
    logic          w_doRead;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_doWrite = we && !full;
    assign w_doRead  = re && !empty;
    assign dout      = r_mem[r_rdPtr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doRead)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doWrite, w_doRead})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while count says the slot is live.
    always_ff @(posedge clk) begin
        if (w_doWrite) r_mem[r_wrPtr] <= din;
    end

endmodule

// File: rtl/ib_vq.sv
// Switch input buffer: queues ingress packets and presents the head with a one-hot request
// to the destination arbiter, discarding bad destinations and counting drops/discards.
module ib_vq
    import sw_pkg::*;
#(
    parameter int PKT_W     = PKT_W_DEF,
    parameter int PORTS     = PORTS_DEF,
    parameter int DST_LSB   = DST_LSB_DEF,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PKT_W-1:0]   pkt_i,
    output logic               full,
    output logic               afull,
    output logic [PKT_W-1:0]   pkt_o,
    output logic [PORTS-1:0]   req,
    input  logic               ack,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   bad_cnt
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          DST_W  = $clog2(PORTS);
    localparam int          VB     = valid_idx(PKT_W);
    localparam int          AF_TH  = (DEPTH > AF_MARGIN) ? DEPTH - AF_MARGIN : 0;
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_TH);

    logic [PKT_W-1:0] w_head;
    logic             w_empty;
    logic             w_fifoFull;
    logic [AW:0]      w_count;
    logic             w_we;
    logic             w_pop;
    logic             w_headGood;
    logic             w_badPop;
    logic             w_drop;
    vq_state_e        r_state;
    vq_state_e        w_nextState;
    logic [PKT_W-1:0] r_pkt;
    logic [PKT_W-1:0] w_nextPkt;
    logic [CNT_W-1:0] r_dropCnt;
    logic [CNT_W-1:0] r_badCnt;

    // Write admission uses the pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign w_we   = pkt_i[VB] && !w_fifoFull;
    assign w_drop = pkt_i[VB] && w_fifoFull;

    ib_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (pkt_i),
        .we    (w_we),
        .re    (w_pop),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_fifoFull),
        .count (w_count)
    );

    if (PORTS == (1 << DST_W)) begin : g_allGood
        assign w_headGood = 1'b1;
    end else begin : g_destCheck
        assign w_headGood = (w_head[DST_LSB +: DST_W] < DST_W'(PORTS));
    end

    assign w_badPop = w_pop && !w_headGood;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pkt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_pkt   <= w_nextPkt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPkt   = r_pkt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_HOLD: begin
                if (ack) begin
                    w_pop       = !w_empty;
                    w_nextState = ST_IDLE;
                    w_nextPkt   = '0;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        // A popped head either becomes the held packet or is thrown away.
        if (w_pop && w_headGood) begin
            w_nextState = ST_HOLD;
            w_nextPkt   = w_head;
        end else if (w_pop) begin
            w_nextState = ST_IDLE;
            w_nextPkt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dropCnt <= '0;
            r_badCnt  <= '0;
        end else begin
            if (clr_cnt)     r_dropCnt <= CNT_W'(w_drop);
            else if (w_drop) r_dropCnt <= CNT_W'(sat_inc(MAX_CNT_W'(r_dropCnt), CNT_W));
            if (clr_cnt)       r_badCnt <= CNT_W'(w_badPop);
            else if (w_badPop) r_badCnt <= CNT_W'(sat_inc(MAX_CNT_W'(r_badCnt), CNT_W));
        end
    end

    assign full     = w_fifoFull;
    assign afull    = (w_count >= AF_LVL);
    assign pkt_o    = r_pkt;
    assign req      = (r_state == ST_HOLD) ? PORTS'(onehot(8'(r_pkt[DST_LSB +: DST_W]))) : '0;
    assign drop_cnt = r_dropCnt;
    assign bad_cnt  = r_badCnt;

endmodule

// File: tb/tb_ib_vq.sv
// Self-checking bench for ib_vq (PORTS=3, DEPTH=8, CNT_W=4) against a queue-based model.
// Directed scenarios first, then a randomized run.
module tb_ib_vq;

    localparam int PKT_W = 16;
    localparam int PORTS = 3;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk;
    logic             rst;
    logic [PKT_W-1:0] pkt_i;
    logic             full;
    logic             afull;
    logic [PKT_W-1:0] pkt_o;
    logic [PORTS-1:0] req;
    logic             ack;
    logic             clr_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] bad_cnt;

    int testCount = 0;
    int failCount = 0;

    logic [PKT_W-1:0] mq[$];
    bit               mHolding;
    logic [PKT_W-1:0] mHeld;
    int               mDrop;
    int               mBad;

    ib_vq #(
        .PKT_W     (PKT_W),
        .PORTS     (PORTS),
        .DST_LSB   (0),
        .DEPTH     (DEPTH),
        .AF_MARGIN (2),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_i    (pkt_i),
        .full     (full),
        .afull    (afull),
        .pkt_o    (pkt_o),
        .req      (req),
        .ack      (ack),
        .clr_cnt  (clr_cnt),
        .drop_cnt (drop_cnt),
        .bad_cnt  (bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mkPkt(input logic [1:0] dest);
        return {1'b1, 13'($urandom), dest};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mHolding = 1'b0;
        mHeld    = '0;
        mDrop    = 0;
        mBad     = 0;
    endtask

    function automatic int satInc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // One clock edge of buffer behaviour, decided from the pre-edge queue contents.
    task automatic modelStep(input logic [PKT_W-1:0] p, input logic a, input logic clr);
        int               preSize;
        bit               doPop;
        bit               dropEv;
        bit               badEv;
        logic [PKT_W-1:0] head;
        preSize = mq.size();
        doPop   = 1'b0;
        dropEv  = 1'b0;
        badEv   = 1'b0;
        if (!mHolding) begin
            doPop = (preSize > 0);
        end else if (a) begin
            mHolding = 1'b0;
            doPop    = (preSize > 0);
        end
        if (doPop) begin
            head = mq.pop_front();
            if (int'(head[1:0]) < PORTS) begin
                mHolding = 1'b1;
                mHeld    = head;
            end else begin
                badEv = 1'b1;
            end
        end
        if (p[PKT_W-1]) begin
            if (preSize < DEPTH) mq.push_back(p);
            else dropEv = 1'b1;
        end
        if (clr) begin
            mDrop = int'(dropEv);
            mBad  = int'(badEv);
        end else begin
            if (dropEv) mDrop = satInc(mDrop);
            if (badEv)  mBad  = satInc(mBad);
        end
    endtask

    task automatic checkAll();
        logic [PORTS-1:0] expReq;
        expReq = mHolding ? PORTS'(1 << mHeld[1:0]) : '0;
        checkOutput("pkt_o",    32'(pkt_o),    mHolding ? 32'(mHeld) : 32'd0);
        checkOutput("req",      32'(req),      32'(expReq));
        checkOutput("full",     32'(full),     32'(mq.size() == DEPTH));
        checkOutput("afull",    32'(afull),    32'(mq.size() >= DEPTH - 2));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrop));
        checkOutput("bad_cnt",  32'(bad_cnt),  32'(mBad));
    endtask

    // Drive one cycle of inputs, advance one edge, then compare just after the edge.
    task automatic applyStimulus(input logic [PKT_W-1:0] p, input logic a, input logic clr);
        pkt_i   = p;
        ack     = a;
        clr_cnt = clr;
        @(posedge clk);
        modelStep(p, a, clr);
        #1;
        checkAll();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            if (mq.size() == 0 && !mHolding) break;
            applyStimulus('0, 1'b1, 1'b0);
        end
        checkOutput("drain_done", 32'(req), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        pkt_i   = mkPkt(2'd2);
        ack     = 1'b0;
        clr_cnt = 1'b0;
        modelReset();

        // Reset held with a valid packet on the input.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_req",   32'(req),      32'd0);
            checkOutput("rst_pkt_o", 32'(pkt_o),    32'd0);
            checkOutput("rst_full",  32'(full),     32'd0);
            checkOutput("rst_afull", 32'(afull),    32'd0);
            checkOutput("rst_drop",  32'(drop_cnt), 32'd0);
            checkOutput("rst_bad",   32'(bad_cnt),  32'd0);
        end
        rst = 1'b1;

        applyStimulus(mkPkt(2'd2), 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("first_req", 32'(req), 32'h4);
        drain();

        // Burst without ack until the FIFO overflows, then continuous retire.
        for (int i = 0; i < 11; i++) applyStimulus(mkPkt(2'(i % 3)), 1'b0, 1'b0);
        checkOutput("burst_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus('0, 1'b1, 1'b0);
            checkOutput("b2b_req", 32'(req != '0), 32'(i < DEPTH));
        end

        // Bad destination in the middle of good ones.
        applyStimulus(mkPkt(2'd1), 1'b0, 1'b0);
        applyStimulus(mkPkt(2'd3), 1'b0, 1'b0);
        applyStimulus(mkPkt(2'd0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus('0, 1'b1, 1'b0);
        drain();

        // Full FIFO: write together with ack/pop is still refused; then saturate drops.
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(mkPkt(2'd1), 1'b0, 1'b0);
        applyStimulus(mkPkt(2'd0), 1'b1, 1'b0);
        checkOutput("pop_wr_full", 32'(full), 32'd0);
        applyStimulus(mkPkt(2'd2), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(mkPkt(2'd2), 1'b0, 1'b0);
        checkOutput("drop_sat", 32'(drop_cnt), 32'd15);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("clr_alone", 32'(drop_cnt), 32'd0);
        applyStimulus(mkPkt(2'd0), 1'b0, 1'b1);
        checkOutput("clr_event", 32'(drop_cnt), 32'd1);
        drain();

        // Reset in the middle of HOLD with packets still queued.
        for (int i = 0; i < 4; i++) applyStimulus(mkPkt(2'd1), 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrst_req",   32'(req),   32'd0);
        checkOutput("midrst_pkt_o", 32'(pkt_o), 32'd0);
        checkOutput("midrst_full",  32'(full),  32'd0);
        checkOutput("midrst_afull", 32'(afull), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(mkPkt(2'd0), 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("post_rst_req", 32'(req), 32'h1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("post_rst_empty", 32'(afull), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [PKT_W-1:0] p;
            p = ($urandom_range(0, 9) < 7) ? mkPkt(2'($urandom_range(0, 3))) : '0;
            applyStimulus(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 3));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
